// File: rtl/icg_enable_ctrl.sv
// icg_enable_ctrl
// Enable sequencer for an integrated clock-gate cell. E and ACK are
// registered on the CLK rising edge, so the gate cell's CLK-low latch
// always sees a stable E.
//
// State machine: OFF -> WAKE -> ON -> DRAIN -> OFF.
// DRAIN can also return to ON when activity reappears.
//
// Ports
//   CLK        free-running source clock, rising-edge active
//   RN         asynchronous active-low reset
//   REQ        activity request, level-sensitive
//   BUSY       gated domain has work in flight; holds the clock on
//   IDLE_LIMIT idle cycles tolerated in ON before gating (quasi-static)
//   TE_IN      scan/test enable from the test controller
//   FORCE      (only with ICG_ENABLE_CTRL_FORCE_EN) holds E/ACK high
//   E          registered functional enable to the gate E pin
//   TE         test enable to the gate TE pin, a combinational copy of TE_IN
//   ACK        registered "gated clock running and stable"
//   STATE      current state (OFF=0, WAKE=1, ON=2, DRAIN=3)
//
// Optional feature macro: ICG_ENABLE_CTRL_FORCE_EN adds the FORCE input.
module icg_enable_ctrl #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2   // 1..15
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              REQ,
    input  logic              BUSY,
    input  logic [IDLE_W-1:0] IDLE_LIMIT,
    input  logic              TE_IN,
`ifdef ICG_ENABLE_CTRL_FORCE_EN
    input  logic              FORCE,
`endif
    output logic              E,
    output logic              TE,
    output logic              ACK,
    output logic [1:0]        STATE
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_WAKE  = 2'd1,
        S_ON    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

    state_t            state, state_nx;
    logic [3:0]        wake_cnt, wake_cnt_nx;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nx;
    logic [IDLE_W:0]   idle_cnt_inc;
    logic              idle, idle_hit, force_en;

`ifdef ICG_ENABLE_CTRL_FORCE_EN
    assign force_en = FORCE;
`else
    assign force_en = 1'b0;
`endif

    assign TE    = TE_IN;
    assign STATE = state;

    assign idle         = !REQ && !BUSY;
    assign idle_cnt_inc = {1'b0, idle_cnt} + {{IDLE_W{1'b0}}, 1'b1};
    // The idle cycle being counted now is included. As a result,
    // IDLE_LIMIT=L gates after L idle cycles, and L=0 still waits one
    // idle cycle.
    assign idle_hit     = idle_cnt_inc >= {1'b0, IDLE_LIMIT};

    always_comb begin
        state_nx    = state;
        wake_cnt_nx = '0;
        idle_cnt_nx = '0;
        case (state)
            S_OFF: begin
                // BUSY alone never wakes the clock
                if (REQ) state_nx = S_WAKE;
            end
            S_WAKE: begin
                // REQ is ignored here: a started wake always completes
                if (wake_cnt == WAKE_LAST) state_nx = S_ON;
                else                       wake_cnt_nx = wake_cnt + 4'd1;
            end
            S_ON: begin
                if (idle) begin
                    if (idle_hit)            state_nx    = S_DRAIN;
                    else if (&idle_cnt)      idle_cnt_nx = idle_cnt;   // saturate
                    else                     idle_cnt_nx = idle_cnt_inc[IDLE_W-1:0];
                end
            end
            S_DRAIN: begin
                state_nx = (REQ || BUSY) ? S_ON : S_OFF;
            end
            default: state_nx = S_OFF;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= S_OFF;
            wake_cnt <= '0;
            idle_cnt <= '0;
            E        <= 1'b0;
            ACK      <= 1'b0;
        end else begin
            state    <= state_nx;
            wake_cnt <= wake_cnt_nx;
            idle_cnt <= idle_cnt_nx;
            // Outputs are decoded from the next state, so they are registered
            // and still stay aligned with STATE.
            E        <= force_en || (state_nx != S_OFF);
            ACK      <= force_en || (state_nx == S_ON);
        end
    end

endmodule

// File: doc/icg_enable_ctrl.md
ICG_ENABLE_CTRL -- requirements
Module: icg_enable_ctrl

Interface
REQ-001: Parameter IDLE_W, default 8, width of the idle-timeout counter and of IDLE_LIMIT.
REQ-002: Parameter WAKE_CYC, default 2, number of CLK cycles E is held high before ACK asserts (1..15).
REQ-003: CLK  input  1  free-running source clock, rising-edge active; the same clock feeds the downstream clock-gate cell.
REQ-004: RN  input  1  reset, asynchronous and active-low.
REQ-005: REQ  input  1  activity request from the gated domain owner; level-sensitive.
REQ-006: BUSY  input  1  gated domain still has work in flight; blocks gating.
REQ-007: IDLE_LIMIT  input  IDLE_W  idle cycles tolerated in ON before gating; quasi-static.
REQ-008: TE_IN  input  1  scan/test enable from the test controller.
REQ-009: E  output  1  functional enable to the clock-gate E pin; registered.
REQ-010: TE  output  1  test enable to the clock-gate TE pin.
REQ-011: ACK  output  1  gated clock is running and stable; registered.
REQ-012: STATE  output  2  current FSM state (OFF=0, WAKE=1, ON=2, DRAIN=3).

Function
REQ-013: E and ACK SHALL change only on the CLK rising edge, so the downstream clock gate's CLK-low transparent latch always samples a stable, glitch-free E.
REQ-014: TE SHALL equal TE_IN combinationally, with no register and no dependency on state or reset.
REQ-015: OFF: E=0, ACK=0; REQ=1 -> WAKE with E=1 from the next cycle.
REQ-016: WAKE: E=1, ACK=0; a wake counter SHALL count WAKE_CYC cycles, then move to ON with ACK=1 in the following cycle.
REQ-017: WAKE with REQ dropped SHALL still complete to ON (no abort mid-wake).
REQ-018: ON: E=1, ACK=1; the idle counter SHALL increment each cycle with REQ=0 and BUSY=0, and clear to 0 on any cycle with REQ=1 or BUSY=1.
REQ-019: ON -> DRAIN when the idle counter equals IDLE_LIMIT while REQ=0 and BUSY=0; IDLE_LIMIT=0 gates after exactly one idle cycle.
REQ-020: The idle counter SHALL saturate at all-ones and never wrap.
REQ-021: DRAIN: ACK=0, E=1 for exactly one cycle, then OFF (E=0).
REQ-022: DRAIN with REQ=1 or BUSY=1 SHALL return to ON (ACK=1 next cycle, idle counter cleared), not to OFF.
REQ-023: OFF with BUSY=1 and REQ=0 SHALL remain in OFF; only REQ wakes the clock.
REQ-024: All ON to OFF paths SHALL pass through DRAIN; no single-cycle ON->OFF transition.

Reset
REQ-025: RN low SHALL asynchronously force STATE=OFF, E=0, ACK=0, and both counters to 0.
REQ-026: RN assertion mid-WAKE or mid-ON SHALL drop E and ACK immediately; after release the FSM SHALL start from OFF and need a fresh REQ.
REQ-027: RN release SHALL take effect on the first CLK rising edge after deassertion; TE SHALL track TE_IN during reset.

Configuration
REQ-028: Macro ICG_ENABLE_CTRL_FORCE_EN SHALL compile in an extra input FORCE (1 bit).
REQ-029: With the macro defined, FORCE=1 SHALL hold the registered E at 1 and ACK at 1 in every state, while the FSM and counters keep running unchanged; FORCE is sampled on CLK.
REQ-030: Without the macro, the FORCE port SHALL be absent, and E and ACK SHALL follow REQ-015..REQ-024 only.

Verification
REQ-031: RN=0, REQ=1, TE_IN=0 -> E=0, ACK=0, STATE=0; TE=0; toggle TE_IN -> TE follows within the same cycle.
REQ-032: WAKE_CYC=2: REQ rises at edge n -> E=1 after edge n+1, ACK=1 after edge n+3, STATE=2.
REQ-033: IDLE_LIMIT=4 in ON, REQ=BUSY=0 -> DRAIN after the 4th idle cycle, OFF one cycle later; BUSY pulse at idle count 3 -> counter clears, and the 4-cycle timeout restarts.
REQ-034: REQ=1 on the DRAIN cycle -> STATE=2 next cycle, ACK=1, E never drops.
REQ-035: RN pulsed low while in ON -> E=0 and ACK=0 asynchronously; after release with REQ=1 -> full WAKE sequence repeats (ACK 3 cycles later).
REQ-036: With ICG_ENABLE_CTRL_FORCE_EN defined, FORCE=1 in OFF -> E=1 and ACK=1 next cycle while STATE stays 0; FORCE=0 -> E=0 next cycle.
